// File: rtl/pipe_valid.sv
// Purpose: parametrised WIDTH-bit payload + valid delay line, DEPTH register stages,
//          with per-stage enable/squash, global flush, occupancy and optional bubble collapse.
// Latency: k edges to stage k with all enables high. No backpressure; en is the stall control.
module pipe_valid #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2,
    parameter int COLLAPSE = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    input  logic [DEPTH-1:0]             en,
    input  logic [DEPTH-1:0]             squash,
    input  logic                         flush,
    output logic [WIDTH*(DEPTH+1)-1:0]   q,
    output logic [DEPTH:0]               q_valid,
    output logic [CW-1:0]                occupancy
);

    // Register index j holds stage j+1; stage 0 is the live input.
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;

    // Every stage 0..DEPTH side by side: index j is the source of register j.
    logic [DEPTH:0][WIDTH-1:0]   all_dat;
    logic [DEPTH:0]              all_vld;

    // cap[j]: register j takes stage j. mv[j]: stage j+1 is taken by stage j+2.
    logic [DEPTH-1:0]            cap;
    logic [DEPTH-1:0]            mv;

    assign all_dat = {data_q, d};
    assign all_vld = {valid_q, d_valid};
    assign q       = all_dat;
    assign q_valid = all_vld;

    // Capture enables: in collapse mode an empty stage always pulls from upstream.
    always_comb begin
        cap = '0;
        for (int j = 0; j < DEPTH; j++) begin
            cap[j] = en[j] | ((COLLAPSE != 0) & ~valid_q[j]);
        end
    end

    // Move detection; the last stage has no downstream and never moves.
    always_comb begin
        mv = '0;
        for (int j = 0; j < DEPTH - 1; j++) begin
            mv[j] = cap[j+1] & ~squash[j+1] & ~flush;
        end
    end

    // Next-state per stage: flush > squash > capture > collapse-invalidate > hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int j = 0; j < DEPTH; j++) begin
            if (flush || squash[j]) begin
                data_d[j]  = '0;
                valid_d[j] = 1'b0;
            end else if (cap[j]) begin
                // Payload follows even when the source is invalid (legacy behaviour).
                data_d[j]  = all_dat[j];
                valid_d[j] = all_vld[j];
            end else if ((COLLAPSE != 0) && mv[j]) begin
                // Entry left without a refill: drop the stale copy, keep payload bits.
                valid_d[j] = 1'b0;
            end
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Occupancy: popcount of the registered valids only, so it never sees input glitches.
    always_comb begin
        occupancy = '0;
        for (int j = 0; j < DEPTH; j++) begin
            occupancy = occupancy + CW'(valid_q[j]);
        end
    end

endmodule

// File: tb/tb_pipe_valid.sv
module tb_pipe_valid;

    logic clk;
    logic resetn;

    // Default instance: WIDTH=32, DEPTH=2, COLLAPSE=0
    logic [31:0] d;
    logic        d_valid;
    logic [1:0]  en;
    logic [1:0]  squash;
    logic        flush;
    logic [95:0] q;
    logic [2:0]  q_valid;
    logic [1:0]  occupancy;

    // Collapse instance: WIDTH=32, DEPTH=3, COLLAPSE=1
    logic [31:0]  c_d;
    logic         c_d_valid;
    logic [2:0]   c_en;
    logic [2:0]   c_squash;
    logic         c_flush;
    logic [127:0] c_q;
    logic [3:0]   c_q_valid;
    logic [1:0]   c_occupancy;

    int n_cmp;
    int n_err;

    pipe_valid u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .d         (d),
        .d_valid   (d_valid),
        .en        (en),
        .squash    (squash),
        .flush     (flush),
        .q         (q),
        .q_valid   (q_valid),
        .occupancy (occupancy)
    );

    pipe_valid #(.WIDTH(32), .DEPTH(3), .COLLAPSE(1)) u_col (
        .clk       (clk),
        .resetn    (resetn),
        .d         (c_d),
        .d_valid   (c_d_valid),
        .en        (c_en),
        .squash    (c_squash),
        .flush     (c_flush),
        .q         (c_q),
        .q_valid   (c_q_valid),
        .occupancy (c_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        d         = 32'hA5A5_A5A5;
        d_valid   = 1'b1;
        en        = 2'b11;
        squash    = 2'b00;
        flush     = 1'b0;
        c_d       = 32'h0;
        c_d_valid = 1'b0;
        c_en      = 3'b000;
        c_squash  = 3'b000;
        c_flush   = 1'b0;

        // Reset state; stage 0 mirrors the inputs
        #3;
        chk("rst_regs",    {32'h0, q[95:32]}, 96'h0);
        chk("rst_stage0",  {96'h0, q[31:0]}, {96'h0, 32'hA5A5_A5A5});
        chk("rst_qvalid",  {125'h0, q_valid}, {125'h0, 3'b001});
        chk("rst_occ",     {126'h0, occupancy}, 128'h0);
        chk("rst_c_qv",    {124'h0, c_q_valid}, 128'h0);
        #4 resetn = 1'b1;

        // Test 1: fill the pipe, then reset mid-cycle
        step(); step(); step();
        chk("t1_full_s2",  {96'h0, q[95:64]}, {96'h0, 32'hA5A5_A5A5});
        chk("t1_full_occ", {126'h0, occupancy}, {126'h0, 2'd2});
        #2 resetn = 1'b0;
        #1;
        chk("t1_rst_regs", {32'h0, q[95:32]}, 96'h0);
        chk("t1_rst_qv",   {125'h0, q_valid}, {125'h0, 3'b001});
        chk("t1_rst_occ",  {126'h0, occupancy}, 128'h0);
        #1 resetn = 1'b1;

        // Test 2: stream 1,2,3
        step();
        d = 32'd1; d_valid = 1'b1; en = 2'b11;
        step(); d = 32'd2;
        step(); d = 32'd3;
        step();
        chk("t2_s1",  {96'h0, q[63:32]}, {96'h0, 32'd3});
        chk("t2_s2",  {96'h0, q[95:64]}, {96'h0, 32'd2});
        chk("t2_qv",  {125'h0, q_valid}, {125'h0, 3'b111});
        chk("t2_occ", {126'h0, occupancy}, {126'h0, 2'd2});

        // Test 3: squash beats enable on stage 1; stage 2 still takes old stage 1
        d = 32'h10;
        step();
        chk("t3_pre_s1", {96'h0, q[63:32]}, {96'h0, 32'h10});
        d = 32'h20; squash = 2'b01;
        step();
        squash = 2'b00;
        chk("t3_s1",  {96'h0, q[63:32]}, 128'h0);
        chk("t3_s2",  {96'h0, q[95:64]}, {96'h0, 32'h10});
        chk("t3_qv",  {125'h0, q_valid[2:1]}, {126'h0, 2'b10});
        chk("t3_occ", {126'h0, occupancy}, {126'h0, 2'd1});

        // Test 4: legacy duplicate with en=10
        flush = 1'b1;
        step();
        flush = 1'b0; d = 32'h7; d_valid = 1'b1; en = 2'b01;
        step();
        chk("t4_pre_qv", {125'h0, q_valid}, {125'h0, 3'b011});
        d = 32'h99; d_valid = 1'b0; en = 2'b10;
        step();
        chk("t4_s1",  {96'h0, q[63:32]}, {96'h0, 32'h7});
        chk("t4_s2",  {96'h0, q[95:64]}, {96'h0, 32'h7});
        chk("t4_qv",  {125'h0, q_valid}, {125'h0, 3'b110});
        chk("t4_occ", {126'h0, occupancy}, {126'h0, 2'd2});

        // Test 6: flush beats enable on a full pipe, then d loads normally
        d = 32'h55; d_valid = 1'b1; en = 2'b11; flush = 1'b1;
        step();
        chk("t6_regs", {32'h0, q[95:32]}, 96'h0);
        chk("t6_qv",   {125'h0, q_valid}, {125'h0, 3'b001});
        chk("t6_occ",  {126'h0, occupancy}, 128'h0);
        flush = 1'b0;
        step();
        chk("t6_s1",  {96'h0, q[63:32]}, {96'h0, 32'h55});
        chk("t6_qv2", {125'h0, q_valid}, {125'h0, 3'b011});
        chk("t6_occ2", {126'h0, occupancy}, {126'h0, 2'd1});

        // Test 5: collapse, en=000; entry slides to the last stage and stays
        c_d = 32'h7; c_d_valid = 1'b1; c_en = 3'b000;
        step();
        chk("t5_setup_qv", {124'h0, c_q_valid}, {124'h0, 4'b0011});
        c_d = 32'hEE; c_d_valid = 1'b0;
        step();
        chk("t5_e1_s2", {96'h0, c_q[95:64]}, {96'h0, 32'h7});
        chk("t5_e1_qv", {124'h0, c_q_valid}, {124'h0, 4'b0100});
        step();
        chk("t5_e2_s3", {96'h0, c_q[127:96]}, {96'h0, 32'h7});
        chk("t5_e2_qv", {124'h0, c_q_valid}, {124'h0, 4'b1000});
        step();
        chk("t5_e3_s3",  {96'h0, c_q[127:96]}, {96'h0, 32'h7});
        chk("t5_e3_qv",  {124'h0, c_q_valid}, {124'h0, 4'b1000});
        chk("t5_e3_occ", {126'h0, c_occupancy}, {126'h0, 2'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
